// File: rtl/regfile_scheduler_if.sv
// Issue and writeback handshake bundle for regfile_scheduler.
//   issue     : iss_valid/iss_ready, source addresses A1/A2, source-file
//               selector regType, destination (wb, dest, desType)
//   scalar wb : se_valid/se_ready, se_A3, se_data (21 bit)
//   vector wb : ve_valid/ve_ready, ve_A3, ve_data (192 bit)
// master = decode/writeback side, slave = scheduler.
interface regfile_scheduler_if;
  logic         iss_valid;
  logic         iss_ready;
  logic [3:0]   iss_A1;
  logic [3:0]   iss_A2;
  logic [1:0]   iss_regType;
  logic         iss_wb;
  logic [3:0]   iss_dest;
  logic         iss_desType;
  logic         se_valid;
  logic         se_ready;
  logic [3:0]   se_A3;
  logic [20:0]  se_data;
  logic         ve_valid;
  logic         ve_ready;
  logic [3:0]   ve_A3;
  logic [191:0] ve_data;

  modport master (
    output iss_valid, iss_A1, iss_A2, iss_regType, iss_wb, iss_dest, iss_desType,
    output se_valid, se_A3, se_data, ve_valid, ve_A3, ve_data,
    input  iss_ready, se_ready, ve_ready
  );

  modport slave (
    input  iss_valid, iss_A1, iss_A2, iss_regType, iss_wb, iss_dest, iss_desType,
    input  se_valid, se_A3, se_data, ve_valid, ve_A3, ve_data,
    output iss_ready, se_ready, ve_ready
  );
endinterface

// File: rtl/regfile_scheduler.sv
// Sequencer in front of the dual scalar/vector register file.
// Arbitrates the single write port between the scalar and vector writeback
// units, issues reads for decode, and keeps a pending-write scoreboard so
// decode never reads or overwrites a register with a write in flight.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   bus (slave)           issue + scalar/vector writeback handshakes
//   Reg_Read, A1, A2,     registered read command to the register file
//   regType
//   Reg_write, A3,        registered write command to the register file
//   desType, wd3e, wd3v
//   rd_valid              RF read outputs hold the data of a read
//   busy                  any write pending
//   err_addr              sticky illegal-address flag
module regfile_scheduler #(
  parameter int NUM_REGS = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_scheduler_if.slave   bus,
  output logic                 Reg_Read,
  output logic                 Reg_write,
  output logic [3:0]           A1,
  output logic [3:0]           A2,
  output logic [3:0]           A3,
  output logic [1:0]           regType,
  output logic                 desType,
  output logic [20:0]          wd3e,
  output logic [191:0]         wd3v,
  output logic                 rd_valid,
  output logic                 busy,
  output logic                 err_addr
);

  // One-hot decode; illegal addresses decode to zero, so they are never
  // tracked and never report pending.
  function automatic logic [NUM_REGS-1:0] addr_dec(input logic [3:0] addr);
    logic [NUM_REGS-1:0] hot;
    hot = '0;
    for (int i = 0; i < NUM_REGS; i++) hot[i] = (addr == 4'(i));
    return hot;
  endfunction

  logic [NUM_REGS-1:0] pend_e_q, pend_e_d, pend_v_q, pend_v_d;
  logic                prio_q, prio_d;          // 0: scalar wins next contention
  logic                reg_read_q, reg_read_d;
  logic [3:0]          a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
  logic [1:0]          regtype_q, regtype_d;
  logic                reg_write_q, reg_write_d;
  logic                destype_q, destype_d;
  logic [20:0]         wd3e_q, wd3e_d;
  logic [191:0]        wd3v_q, wd3v_d;
  logic                rd_valid_q, rd_valid_d;
  logic                err_q, err_d;

  logic src1_used, src1_vec, src2_used, src2_vec;
  logic raw, waw, accept, se_gnt, ve_gnt;
  logic bad_issue, bad_write;
  logic [NUM_REGS-1:0] clr_mask, set_mask;

  // Hazard and arbitration
  always_comb begin
    // regType: 00 A2 scalar, 01 A1 scalar/A2 vector, 10 none, 11 both vector
    src1_used = bus.iss_regType[0];
    src1_vec  = bus.iss_regType[1];
    src2_used = (bus.iss_regType != 2'b10);
    src2_vec  = bus.iss_regType[0];

    raw = (src1_used && |((src1_vec ? pend_v_q : pend_e_q) & addr_dec(bus.iss_A1))) ||
          (src2_used && |((src2_vec ? pend_v_q : pend_e_q) & addr_dec(bus.iss_A2)));
    waw = bus.iss_wb && |((bus.iss_desType ? pend_v_q : pend_e_q) & addr_dec(bus.iss_dest));

    bus.iss_ready = !rst && !raw && !waw;
    accept        = bus.iss_valid && bus.iss_ready;

    se_gnt = !rst && bus.se_valid && (!bus.ve_valid || !prio_q);
    ve_gnt = !rst && bus.ve_valid && (!bus.se_valid ||  prio_q);
    bus.se_ready = se_gnt;
    bus.ve_ready = ve_gnt;
  end

  // Next-state
  always_comb begin
    prio_d = prio_q ^ (bus.se_valid && bus.ve_valid);

    reg_read_d = accept;
    a1_d       = accept ? bus.iss_A1      : a1_q;
    a2_d       = accept ? bus.iss_A2      : a2_q;
    regtype_d  = accept ? bus.iss_regType : regtype_q;
    rd_valid_d = reg_read_q;

    reg_write_d = se_gnt || ve_gnt;
    a3_d      = se_gnt ? bus.se_A3 : (ve_gnt ? bus.ve_A3 : a3_q);
    destype_d = se_gnt ? 1'b0 : (ve_gnt ? 1'b1 : destype_q);
    wd3e_d    = se_gnt ? bus.se_data : wd3e_q;
    wd3v_d    = ve_gnt ? bus.ve_data : wd3v_q;

    // Clear is applied before set so a same-cycle set of the same bit wins.
    clr_mask = reg_write_q ? addr_dec(a3_q) : '0;
    set_mask = (accept && bus.iss_wb) ? addr_dec(bus.iss_dest) : '0;
    pend_e_d = (pend_e_q & ~(destype_q ? '0 : clr_mask)) | (bus.iss_desType ? '0 : set_mask);
    pend_v_d = (pend_v_q & ~(destype_q ? clr_mask : '0)) | (bus.iss_desType ? set_mask : '0);

    bad_issue = accept && ((src1_used && addr_dec(bus.iss_A1) == '0) ||
                           (src2_used && addr_dec(bus.iss_A2) == '0) ||
                           (bus.iss_wb && addr_dec(bus.iss_dest) == '0));
    bad_write = (se_gnt && addr_dec(bus.se_A3) == '0) ||
                (ve_gnt && addr_dec(bus.ve_A3) == '0);
    err_d     = err_q || bad_issue || bad_write;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_e_q    <= '0;
      pend_v_q    <= '0;
      prio_q      <= 1'b0;
      reg_read_q  <= 1'b0;
      a1_q        <= '0;
      a2_q        <= '0;
      regtype_q   <= '0;
      reg_write_q <= 1'b0;
      a3_q        <= '0;
      destype_q   <= 1'b0;
      wd3e_q      <= '0;
      wd3v_q      <= '0;
      rd_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pend_e_q    <= pend_e_d;
      pend_v_q    <= pend_v_d;
      prio_q      <= prio_d;
      reg_read_q  <= reg_read_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      regtype_q   <= regtype_d;
      reg_write_q <= reg_write_d;
      a3_q        <= a3_d;
      destype_q   <= destype_d;
      wd3e_q      <= wd3e_d;
      wd3v_q      <= wd3v_d;
      rd_valid_q  <= rd_valid_d;
      err_q       <= err_d;
    end
  end

  assign Reg_Read  = reg_read_q;
  assign A1        = a1_q;
  assign A2        = a2_q;
  assign regType   = regtype_q;
  assign Reg_write = reg_write_q;
  assign A3        = a3_q;
  assign desType   = destype_q;
  assign wd3e      = wd3e_q;
  assign wd3v      = wd3v_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = |{pend_e_q, pend_v_q};
  assign err_addr  = err_q;

endmodule

// File: tb/tb_regfile_scheduler.sv
module tb_regfile_scheduler;
  localparam int N = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_scheduler_if bus_if ();

  logic         rf_reg_read, rf_reg_write, rf_des_type, rf_rd_valid, rf_busy, rf_err;
  logic [3:0]   rf_a1, rf_a2, rf_a3;
  logic [1:0]   rf_reg_type;
  logic [20:0]  rf_wd3e;
  logic [191:0] rf_wd3v;

  regfile_scheduler #(.NUM_REGS(N)) dut (
    .clk(clk), .rst(rst), .bus(bus_if),
    .Reg_Read(rf_reg_read), .Reg_write(rf_reg_write),
    .A1(rf_a1), .A2(rf_a2), .A3(rf_a3), .regType(rf_reg_type), .desType(rf_des_type),
    .wd3e(rf_wd3e), .wd3v(rf_wd3v), .rd_valid(rf_rd_valid), .busy(rf_busy), .err_addr(rf_err)
  );

  // Register file behaviour driven by the DUT commands (write port, registered read of A2).
  logic [20:0]  tb_rf_e [16];
  logic [191:0] tb_rf_v [16];
  logic [191:0] tb_r2;
  always @(posedge clk) begin
    if (rf_reg_write) begin
      if (rf_des_type) tb_rf_v[rf_a3] <= rf_wd3v;
      else             tb_rf_e[rf_a3] <= rf_wd3e;
    end
    if (rf_reg_read) tb_r2 <= (rf_reg_type == 2'b00) ? {171'b0, tb_rf_e[rf_a2]} : tb_rf_v[rf_a2];
  end

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  bit           m_pend [2][N];      // [0]=scalar file, [1]=vector file
  bit           m_turn;             // whose turn on contention: 0 scalar, 1 vector
  bit           m_err;
  bit           m_iss_ready, m_se_ready, m_ve_ready, m_accept, m_busy;
  int           m_gnt;              // 0 none, 1 scalar, 2 vector
  bit           e_rr, e_rw, e_des, e_rdv;
  logic [3:0]   e_a1, e_a2, e_a3;
  logic [1:0]   e_rt;
  logic [20:0]  e_wd3e;
  logic [191:0] e_wd3v;

  function automatic bit pending(input int file, input logic [3:0] addr);
    if (int'(addr) >= N) return 1'b0;
    return m_pend[file][int'(addr)];
  endfunction

  task automatic model_eval();
    bit haz;
    case (bus_if.iss_regType)
      2'b00:   haz = pending(0, bus_if.iss_A2);
      2'b01:   haz = pending(0, bus_if.iss_A1) || pending(1, bus_if.iss_A2);
      2'b11:   haz = pending(1, bus_if.iss_A1) || pending(1, bus_if.iss_A2);
      default: haz = 1'b0;
    endcase
    if (bus_if.iss_wb && pending(int'(bus_if.iss_desType), bus_if.iss_dest)) haz = 1'b1;
    m_iss_ready = !rst && !haz;
    m_accept    = m_iss_ready && bus_if.iss_valid;
    m_gnt = 0;
    if (!rst) begin
      if (bus_if.se_valid && bus_if.ve_valid) m_gnt = m_turn ? 2 : 1;
      else if (bus_if.se_valid)               m_gnt = 1;
      else if (bus_if.ve_valid)               m_gnt = 2;
    end
    m_se_ready = (m_gnt == 1);
    m_ve_ready = (m_gnt == 2);
    m_busy = 1'b0;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < N; i++) m_busy |= m_pend[f][i];
  endtask

  task automatic model_commit();
    bit old_rr, old_rw, old_des, bad;
    logic [3:0] old_a3;
    model_eval();
    if (rst) begin
      for (int f = 0; f < 2; f++) for (int i = 0; i < N; i++) m_pend[f][i] = 1'b0;
      m_turn = 0; m_err = 0;
      e_rr = 0; e_rw = 0; e_des = 0; e_rdv = 0;
      e_a1 = 0; e_a2 = 0; e_a3 = 0; e_rt = 0; e_wd3e = 0; e_wd3v = 0;
      return;
    end
    old_rr = e_rr; old_rw = e_rw; old_des = e_des; old_a3 = e_a3;
    e_rdv = old_rr;
    if (old_rw && int'(old_a3) < N) m_pend[int'(old_des)][int'(old_a3)] = 1'b0;
    e_rr = m_accept;
    if (m_accept) begin
      e_a1 = bus_if.iss_A1; e_a2 = bus_if.iss_A2; e_rt = bus_if.iss_regType;
      if (bus_if.iss_wb && int'(bus_if.iss_dest) < N)
        m_pend[int'(bus_if.iss_desType)][int'(bus_if.iss_dest)] = 1'b1;
      bad = 0;
      case (bus_if.iss_regType)
        2'b00:        bad = int'(bus_if.iss_A2) >= N;
        2'b01, 2'b11: bad = int'(bus_if.iss_A1) >= N || int'(bus_if.iss_A2) >= N;
        default:      bad = 0;
      endcase
      if (bus_if.iss_wb && int'(bus_if.iss_dest) >= N) bad = 1;
      if (bad) m_err = 1;
    end
    e_rw = (m_gnt != 0);
    if (m_gnt == 1) begin
      e_des = 0; e_a3 = bus_if.se_A3; e_wd3e = bus_if.se_data;
      if (int'(bus_if.se_A3) >= N) m_err = 1;
    end else if (m_gnt == 2) begin
      e_des = 1; e_a3 = bus_if.ve_A3; e_wd3v = bus_if.ve_data;
      if (int'(bus_if.ve_A3) >= N) m_err = 1;
    end
    if (bus_if.se_valid && bus_if.ve_valid) m_turn = !m_turn;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.iss_valid = 0; bus_if.iss_A1 = 0; bus_if.iss_A2 = 0; bus_if.iss_regType = 2'b10;
    bus_if.iss_wb = 0; bus_if.iss_dest = 0; bus_if.iss_desType = 0;
    bus_if.se_valid = 0; bus_if.se_A3 = 0; bus_if.se_data = 0;
    bus_if.ve_valid = 0; bus_if.ve_A3 = 0; bus_if.ve_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic set_issue(input bit v, input logic [1:0] rt, input logic [3:0] a1, input logic [3:0] a2,
                           input bit wb, input bit des, input logic [3:0] dest);
    bus_if.iss_valid = v; bus_if.iss_regType = rt; bus_if.iss_A1 = a1; bus_if.iss_A2 = a2;
    bus_if.iss_wb = wb; bus_if.iss_desType = des; bus_if.iss_dest = dest;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1;
    set_issue(1, 2'b00, 0, 0, 0, 0, 0);
    bus_if.se_valid = 1; bus_if.se_A3 = 1; bus_if.se_data = 21'h1;
    bus_if.ve_valid = 1; bus_if.ve_A3 = 1; bus_if.ve_data = 192'h1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (bus_if.iss_ready !== 1'b0) begin errors++; $display("FAIL reset_iss_ready got %b exp 0", bus_if.iss_ready); end
      checks++; if (bus_if.se_ready !== 1'b0) begin errors++; $display("FAIL reset_se_ready got %b exp 0", bus_if.se_ready); end
      checks++; if (bus_if.ve_ready !== 1'b0) begin errors++; $display("FAIL reset_ve_ready got %b exp 0", bus_if.ve_ready); end
      tick();
    end
    rst = 0;
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({rf_reg_read, rf_reg_write, rf_rd_valid, rf_a1, rf_a2, rf_a3, rf_reg_type, rf_des_type, rf_busy, rf_err} !== '0)
      begin errors++; $display("FAIL reset_ctrl_outputs got rr=%b rw=%b rdv=%b a1=%h a2=%h a3=%h rt=%b des=%b busy=%b err=%b exp all 0",
        rf_reg_read, rf_reg_write, rf_rd_valid, rf_a1, rf_a2, rf_a3, rf_reg_type, rf_des_type, rf_busy, rf_err); end
    checks++; if (rf_wd3e !== 21'h0) begin errors++; $display("FAIL reset_wd3e got %h exp 0", rf_wd3e); end
    checks++; if (rf_wd3v !== 192'h0) begin errors++; $display("FAIL reset_wd3v got %h exp 0", rf_wd3v); end
    tick();
  endtask

  task automatic test_raw_stall();
    do_reset();
    set_issue(1, 2'b10, 0, 0, 1, 0, 4'd3);
    @(negedge clk);
    checks++; if (bus_if.iss_ready !== 1'b1) begin errors++; $display("FAIL raw_first_issue got %b exp 1", bus_if.iss_ready); end
    tick();
    set_issue(1, 2'b00, 4'd3, 4'd3, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (bus_if.iss_ready !== 1'b0) begin errors++; $display("FAIL raw_stall got %b exp 0", bus_if.iss_ready); end
      tick();
    end
    bus_if.se_valid = 1; bus_if.se_A3 = 4'd3; bus_if.se_data = 21'h15A5A;
    @(negedge clk);
    checks++; if (bus_if.se_ready !== 1'b1) begin errors++; $display("FAIL raw_se_grant got %b exp 1", bus_if.se_ready); end
    checks++; if (bus_if.iss_ready !== 1'b0) begin errors++; $display("FAIL raw_stall_t got %b exp 0", bus_if.iss_ready); end
    tick();
    bus_if.se_valid = 0;
    @(negedge clk);
    checks++; if (bus_if.iss_ready !== 1'b0) begin errors++; $display("FAIL raw_stall_t1 got %b exp 0", bus_if.iss_ready); end
    checks++;
    if ({rf_reg_write, rf_des_type, rf_a3, rf_wd3e} !== {1'b1, 1'b0, 4'd3, 21'h15A5A})
      begin errors++; $display("FAIL raw_write_cmd got rw=%b des=%b a3=%h wd3e=%h exp 1 0 3 15a5a", rf_reg_write, rf_des_type, rf_a3, rf_wd3e); end
    tick();
    @(negedge clk);
    checks++; if (bus_if.iss_ready !== 1'b1) begin errors++; $display("FAIL raw_ready_t2 got %b exp 1", bus_if.iss_ready); end
    tick();
    bus_if.iss_valid = 0;
    @(negedge clk);
    checks++;
    if ({rf_reg_read, rf_a2, rf_reg_type} !== {1'b1, 4'd3, 2'b00})
      begin errors++; $display("FAIL raw_read_t3 got rr=%b a2=%h rt=%b exp 1 3 00", rf_reg_read, rf_a2, rf_reg_type); end
    tick();
    @(negedge clk);
    checks++; if (rf_rd_valid !== 1'b1) begin errors++; $display("FAIL raw_rd_valid_t4 got %b exp 1", rf_rd_valid); end
    checks++; if (tb_r2[20:0] !== 21'h15A5A) begin errors++; $display("FAIL raw_read_data got %h exp 15a5a", tb_r2[20:0]); end
    tick();
    @(negedge clk);
    checks++; if (rf_rd_valid !== 1'b0) begin errors++; $display("FAIL raw_rd_valid_t5 got %b exp 0", rf_rd_valid); end
    checks++; if (rf_busy !== 1'b0) begin errors++; $display("FAIL raw_busy_end got %b exp 0", rf_busy); end
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus_if.se_valid = (i < 4); bus_if.ve_valid = (i < 4);
      bus_if.se_A3 = 4'(i); bus_if.ve_A3 = 4'(i);
      bus_if.se_data = 21'($urandom); bus_if.ve_data = {6{$urandom}};
      @(negedge clk);
      if (i < 4) begin
        checks++;
        if ({bus_if.se_ready, bus_if.ve_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
          begin errors++; $display("FAIL contend_grant_%0d got se=%b ve=%b exp %s", i, bus_if.se_ready, bus_if.ve_ready, (i % 2 == 0) ? "S" : "V"); end
      end
      if (i > 0) begin
        checks++;
        if ({rf_reg_write, rf_des_type} !== {1'b1, ((i - 1) % 2 == 1)})
          begin errors++; $display("FAIL contend_write_%0d got rw=%b des=%b exp 1 %0d", i, rf_reg_write, rf_des_type, (i - 1) % 2); end
      end
      tick();
    end
    bus_if.se_valid = 0; bus_if.ve_valid = 0;
    @(negedge clk);
    checks++; if (rf_reg_write !== 1'b0) begin errors++; $display("FAIL contend_idle_write got %b exp 0", rf_reg_write); end
  endtask

  task automatic test_waw();
    logic [191:0] d;
    do_reset();
    set_issue(1, 2'b10, 0, 0, 1, 1, 4'd5);
    @(negedge clk);
    checks++; if (bus_if.iss_ready !== 1'b1) begin errors++; $display("FAIL waw_first got %b exp 1", bus_if.iss_ready); end
    tick();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if ({bus_if.iss_ready, rf_busy} !== 2'b01) begin errors++; $display("FAIL waw_stall got ready=%b busy=%b exp 0 1", bus_if.iss_ready, rf_busy); end
      tick();
    end
    d = {6{$urandom}};
    bus_if.ve_valid = 1; bus_if.ve_A3 = 4'd5; bus_if.ve_data = d;
    @(negedge clk);
    checks++; if ({bus_if.iss_ready, bus_if.ve_ready, rf_busy} !== 3'b011) begin errors++; $display("FAIL waw_grant got ready=%b ve=%b busy=%b exp 0 1 1", bus_if.iss_ready, bus_if.ve_ready, rf_busy); end
    tick();
    bus_if.ve_valid = 0;
    @(negedge clk);
    checks++; if ({bus_if.iss_ready, rf_busy} !== 2'b01) begin errors++; $display("FAIL waw_t1 got ready=%b busy=%b exp 0 1", bus_if.iss_ready, rf_busy); end
    checks++; if ({rf_reg_write, rf_des_type, rf_a3} !== {1'b1, 1'b1, 4'd5} || rf_wd3v !== d)
      begin errors++; $display("FAIL waw_write_cmd got rw=%b des=%b a3=%h wd3v=%h exp 1 1 5 %h", rf_reg_write, rf_des_type, rf_a3, rf_wd3v, d); end
    tick();
    @(negedge clk);
    checks++; if (bus_if.iss_ready !== 1'b1) begin errors++; $display("FAIL waw_ready_t2 got %b exp 1", bus_if.iss_ready); end
    tick();
    bus_if.iss_valid = 0;
    bus_if.ve_valid = 1; bus_if.ve_A3 = 4'd5;
    @(negedge clk);
    checks++; if (rf_busy !== 1'b1) begin errors++; $display("FAIL waw_busy_second got %b exp 1", rf_busy); end
    tick();
    bus_if.ve_valid = 0;
    tick();
    @(negedge clk);
    checks++; if (rf_busy !== 1'b0) begin errors++; $display("FAIL waw_busy_final got %b exp 0", rf_busy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 7; k++) begin
      set_issue(k < 4, 2'b11, 4'(k), 4'(k + 1), 0, 0, 0);
      @(negedge clk);
      if (k < 4) begin
        checks++; if (bus_if.iss_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d got %b exp 1", k, bus_if.iss_ready); end
      end
      checks++;
      if ({rf_reg_read, rf_rd_valid} !== {(k >= 1 && k <= 4), (k >= 2 && k <= 5)})
        begin errors++; $display("FAIL b2b_pipe_%0d got rr=%b rdv=%b exp %b %b", k, rf_reg_read, rf_rd_valid, (k >= 1 && k <= 4), (k >= 2 && k <= 5)); end
      if (k >= 1 && k <= 4) begin
        checks++; if ({rf_a1, rf_a2, rf_reg_type} !== {4'(k - 1), 4'(k), 2'b11})
          begin errors++; $display("FAIL b2b_addr_%0d got a1=%h a2=%h rt=%b exp %h %h 11", k, rf_a1, rf_a2, rf_reg_type, k - 1, k); end
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    do_reset();
    bus_if.se_valid = 1; bus_if.se_A3 = 4'd7; bus_if.se_data = 21'h0ABCD;
    @(negedge clk);
    checks++; if ({bus_if.se_ready, rf_err} !== 2'b10) begin errors++; $display("FAIL illegal_grant got se=%b err=%b exp 1 0", bus_if.se_ready, rf_err); end
    tick();
    bus_if.se_valid = 0;
    set_issue(1, 2'b00, 0, 4'd1, 1, 0, 4'd9);
    @(negedge clk);
    checks++; if ({rf_err, rf_reg_write, rf_a3, rf_busy} !== {1'b1, 1'b1, 4'd7, 1'b0})
      begin errors++; $display("FAIL illegal_forward got err=%b rw=%b a3=%h busy=%b exp 1 1 7 0", rf_err, rf_reg_write, rf_a3, rf_busy); end
    checks++; if (bus_if.iss_ready !== 1'b1) begin errors++; $display("FAIL illegal_sb_unchanged got %b exp 1", bus_if.iss_ready); end
    tick();
    bus_if.iss_valid = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if ({rf_err, rf_busy} !== 2'b10) begin errors++; $display("FAIL illegal_sticky got err=%b busy=%b exp 1 0", rf_err, rf_busy); end
      tick();
    end
    do_reset();
    @(negedge clk);
    checks++; if (rf_err !== 1'b0) begin errors++; $display("FAIL illegal_cleared got %b exp 0", rf_err); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      set_issue($urandom_range(0, 3) != 0, 2'($urandom), 4'($urandom_range(0, N - 1)), 4'($urandom_range(0, N - 1)),
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 4'($urandom_range(0, N - 1)));
      bus_if.se_valid = ($urandom_range(0, 2) != 0); bus_if.se_A3 = 4'($urandom_range(0, N - 1)); bus_if.se_data = 21'($urandom);
      bus_if.ve_valid = ($urandom_range(0, 2) != 0); bus_if.ve_A3 = 4'($urandom_range(0, N - 1)); bus_if.ve_data = {6{$urandom}};
      @(negedge clk);
      model_eval();
      checks++;
      if ({bus_if.iss_ready, bus_if.se_ready, bus_if.ve_ready} !== {m_iss_ready, m_se_ready, m_ve_ready})
        begin errors++; $display("FAIL rand_ready c%0d got iss=%b se=%b ve=%b exp %b %b %b", c, bus_if.iss_ready, bus_if.se_ready, bus_if.ve_ready, m_iss_ready, m_se_ready, m_ve_ready); end
      checks++;
      if ({rf_busy, rf_err, rf_reg_read, rf_reg_write, rf_rd_valid} !== {m_busy, m_err, e_rr, e_rw, e_rdv})
        begin errors++; $display("FAIL rand_status c%0d got busy=%b err=%b rr=%b rw=%b rdv=%b exp %b %b %b %b %b", c, rf_busy, rf_err, rf_reg_read, rf_reg_write, rf_rd_valid, m_busy, m_err, e_rr, e_rw, e_rdv); end
      checks++;
      if ({rf_a1, rf_a2, rf_reg_type, rf_a3, rf_des_type, rf_wd3e} !== {e_a1, e_a2, e_rt, e_a3, e_des, e_wd3e} || rf_wd3v !== e_wd3v)
        begin errors++; $display("FAIL rand_cmd c%0d got a1=%h a2=%h rt=%b a3=%h des=%b wd3e=%h exp %h %h %b %h %b %h", c, rf_a1, rf_a2, rf_reg_type, rf_a3, rf_des_type, rf_wd3e, e_a1, e_a2, e_rt, e_a3, e_des, e_wd3e); end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_raw_stall();
    test_contention();
    test_waw();
    test_back_to_back();
    test_illegal();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
